// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing from the 25 MHz pixel clock.
// Stage 0 holds the free-running h/v counters, stage 1 registers the decoded
// coordinates and syncs, and the pins carry blanked colour plus syncs.
// Optional build macro: VGA_OUTPUT_REG_EN adds one register stage on the pins
// (vga_rgb, hsync, vsync); x/y/active/frame_start are unaffected.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic        CLOCK_25,
  input  logic        RESET_N,
  input  logic [2:0]  color,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        active,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  vga_rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Asserted pin level; the deasserted level is its complement.
  localparam logic SYNC_ON = (SYNC_POL != 0);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_vis;
  logic       v_vis;
  logic       hs_on;
  logic       vs_on;
  logic       hsync_s1;
  logic       vsync_s1;

  // Stage 0: pixel counter wraps each line, line counter advances on that wrap.
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= 10'd0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Decode the current counter position into visibility and sync windows.
  always_comb begin
    h_vis = (h_cnt < H_VIS);
    v_vis = (v_cnt < V_VIS);
    hs_on = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    vs_on = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
  end

  // Stage 1: register 1-based coordinates, visibility, frame pulse and syncs.
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      x           <= 12'd0;
      y           <= 12'd0;
      active      <= 1'b0;
      frame_start <= 1'b0;
      hsync_s1    <= ~SYNC_ON;
      vsync_s1    <= ~SYNC_ON;
    end else begin
      active      <= h_vis && v_vis;
      x           <= (h_vis && v_vis) ? {2'b00, h_cnt} + 12'd1 : 12'd0;
      y           <= (h_vis && v_vis) ? {2'b00, v_cnt} + 12'd1 : 12'd0;
      frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
      hsync_s1    <= hs_on ? SYNC_ON : ~SYNC_ON;
      vsync_s1    <= vs_on ? SYNC_ON : ~SYNC_ON;
    end
  end

`ifdef VGA_OUTPUT_REG_EN
  logic [2:0] rgb_s2;
  logic       hsync_s2;
  logic       vsync_s2;

  // Stage 2: register all pins together so colour and syncs stay aligned.
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      rgb_s2   <= 3'b000;
      hsync_s2 <= ~SYNC_ON;
      vsync_s2 <= ~SYNC_ON;
    end else begin
      rgb_s2   <= active ? color : 3'b000;
      hsync_s2 <= hsync_s1;
      vsync_s2 <= vsync_s1;
    end
  end

  // Pins driven from stage 2.
  always_comb begin
    vga_rgb = rgb_s2;
    hsync   = hsync_s2;
    vsync   = vsync_s2;
  end
`else
  // Pins driven from stage 1; colour is blanked combinationally.
  always_comb begin
    vga_rgb = active ? color : 3'b000;
    hsync   = hsync_s1;
    vsync   = vsync_s1;
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen, run with a scaled-down raster so several whole
// frames fit in a short run. Expected outputs come from the pixel index since
// reset release (row/column arithmetic), not from counter logic.
module tb_vga_timing_gen;

  localparam int HA  = 20;
  localparam int HF  = 3;
  localparam int HSW = 5;
  localparam int HB  = 4;
  localparam int VA  = 6;
  localparam int VF  = 2;
  localparam int VSW = 2;
  localparam int VB  = 3;
  localparam int SP  = 0;
  localparam int HT  = HA + HF + HSW + HB;
  localparam int VT  = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;
  localparam logic SYNC_ON = (SP != 0);

  logic        clk;
  logic        RESET_N;
  logic [2:0]  color;
  logic [11:0] x;
  logic [11:0] y;
  logic        active;
  logic        frame_start;
  logic        hsync;
  logic        vsync;
  logic [2:0]  vga_rgb;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .SYNC_POL(SP)
  ) dut (
    .CLOCK_25(clk),
    .RESET_N(RESET_N),
    .color(color),
    .x(x),
    .y(y),
    .active(active),
    .frame_start(frame_start),
    .hsync(hsync),
    .vsync(vsync),
    .vga_rgb(vga_rgb)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int k;          // edges since reset release; 0 while in reset
  int cyc;
  int fs_cyc;
  int vs_run;
  bit fs_seen;

  logic [11:0] ex, ey;
  logic        ea, efs, ehs, evs;
  logic        e_hs, e_vs;
  logic [2:0]  e_rgb;
  logic        pa, phs, pvs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h at t=%0t k=%0d", tag, obs, exp, $time, k);
    end
  endtask

  // Stage-1 expectations for the k-th edge after release: pixel index p
  // maps to column p%HT and row p/HT within the frame.
  task automatic model(input int kk, output logic [11:0] mx, output logic [11:0] my,
                       output logic ma, output logic mfs, output logic mhs, output logic mvs);
    int p, c, r;
    if (kk == 0) begin
      mx = 12'd0; my = 12'd0; ma = 1'b0; mfs = 1'b0;
      mhs = ~SYNC_ON; mvs = ~SYNC_ON;
    end else begin
      p = (kk - 1) % FRAME;
      c = p % HT;
      r = p / HT;
      ma  = (c < HA) && (r < VA);
      mx  = ma ? 12'(c + 1) : 12'd0;
      my  = ma ? 12'(r + 1) : 12'd0;
      mfs = (p == 0);
      mhs = (c >= HA + HF && c < HA + HF + HSW) ? SYNC_ON : ~SYNC_ON;
      mvs = (r >= VA + VF && r < VA + VF + VSW) ? SYNC_ON : ~SYNC_ON;
    end
  endtask

  task automatic check_all();
    check("x", 32'(x), 32'(ex));
    check("y", 32'(y), 32'(ey));
    check("active", 32'(active), 32'(ea));
    check("frame_start", 32'(frame_start), 32'(efs));
    check("hsync", 32'(hsync), 32'(e_hs));
    check("vsync", 32'(vsync), 32'(e_vs));
    check("vga_rgb", 32'(vga_rgb), 32'(e_rgb));
  endtask

  task automatic clear_model();
    k = 0; pa = 1'b0; phs = ~SYNC_ON; pvs = ~SYNC_ON; fs_seen = 1'b0; vs_run = 0;
  endtask

  // One clock: advance the model, change colour after the edge, check at negedge.
  task automatic step();
    logic [2:0] c_prev;
    @(posedge clk);
    c_prev = color;
    if (RESET_N) k++;
    model(k, ex, ey, ea, efs, ehs, evs);
`ifdef VGA_OUTPUT_REG_EN
    e_rgb = pa ? c_prev : 3'd0;
    e_hs  = phs;
    e_vs  = pvs;
`else
    e_hs  = ehs;
    e_vs  = evs;
`endif
    pa = ea; phs = ehs; pvs = evs;
    #1 color = 3'($urandom_range(0, 7));
    @(negedge clk);
`ifndef VGA_OUTPUT_REG_EN
    e_rgb = ea ? color : 3'd0;
`endif
    check_all();
    cyc++;
    if (vsync === SYNC_ON) vs_run++;
    if (frame_start === 1'b1) begin
      if (fs_seen) begin
        check("fs_period", 32'(cyc - fs_cyc), 32'(FRAME));
        check("vsync_len", 32'(vs_run), 32'(VSW * HT));
      end
      fs_seen = 1'b1;
      fs_cyc  = cyc;
      vs_run  = 0;
    end
  endtask

  initial begin
    RESET_N = 1'b0;
    color   = 3'd0;
    cyc     = 0;
    fs_cyc  = 0;
    clear_model();

    repeat (5) step();
    RESET_N = 1'b1;

    step();
    check("first_x", 32'(x), 32'd1);
    check("first_fs", 32'(frame_start), 32'd1);
    repeat (2 * FRAME + 10) step();

    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(50, FRAME)) step();
      @(posedge clk);
      #2 RESET_N = 1'b0;
      #1;
      clear_model();
      model(0, ex, ey, ea, efs, ehs, evs);
      e_hs = ~SYNC_ON; e_vs = ~SYNC_ON; e_rgb = 3'd0;
      check_all();
      repeat (3) step();
      RESET_N = 1'b1;
      step();
      check("restart_y", 32'(y), 32'd1);
      repeat (FRAME + 40) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
